// File: rtl/mem_access_unit.sv
// Memory-stage controller: turns execute requests into block-RAM accesses and
// produces a registered writeback result, stalling execute for one cycle per load.
module mem_access_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              flush,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic              ex_reg_wr_en,
    input  logic [7:0]        alu_operation,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       reg_data_b,
    input  logic [4:0]        rd_addr,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              wb_valid,
    output logic              wb_reg_wr_en,
    output logic [4:0]        wb_rd_addr,
    output logic [31:0]       wb_data,
    output logic              misaligned_err
);

    localparam logic [7:0] OP_LB  = 8'h10;
    localparam logic [7:0] OP_LH  = 8'h11;
    localparam logic [7:0] OP_LW  = 8'h12;
    localparam logic [7:0] OP_LBU = 8'h13;
    localparam logic [7:0] OP_LHU = 8'h14;
    localparam logic [7:0] OP_SB  = 8'h18;
    localparam logic [7:0] OP_SH  = 8'h19;
    localparam logic [7:0] OP_SW  = 8'h1A;

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t      state;
    logic [1:0]  ld_offset;
    logic [7:0]  ld_op;
    logic [4:0]  ld_rd;

    logic        accept;
    logic        illegal;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        do_store;
    logic        do_load;
    logic [1:0]  offset;
    logic [3:0]  store_we;
    logic [31:0] store_wdata;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;

    // Upper address bits are deliberately dropped so accesses wrap within the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, alu_result[31:ADDR_W+2]};

    assign offset     = alu_result[1:0];
    assign ex_ready   = (state == IDLE);
    assign accept     = ex_valid && ex_ready && !flush;
    assign illegal    = mem_rd_en && mem_wr_en;
    assign is_half    = (alu_operation == OP_LH) || (alu_operation == OP_LHU) ||
                        (alu_operation == OP_SH);
    assign is_word    = (alu_operation == OP_LW) || (alu_operation == OP_SW);
    assign misaligned = (mem_rd_en || mem_wr_en) &&
                        ((is_half && offset[0]) || (is_word && (offset != 2'b00)));
    assign do_store   = accept && !illegal && !misaligned && mem_wr_en;
    assign do_load    = accept && !illegal && !misaligned && mem_rd_en;

    always_comb begin
        store_we    = 4'b0000;
        store_wdata = reg_data_b;
        case (alu_operation)
            OP_SB: begin
                store_we    = 4'b0001 << offset;
                store_wdata = {4{reg_data_b[7:0]}};
            end
            OP_SH: begin
                store_we    = 4'b0011 << offset;
                store_wdata = {2{reg_data_b[15:0]}};
            end
            OP_SW: begin
                store_we    = 4'b1111;
                store_wdata = reg_data_b;
            end
            default: begin
                store_we    = 4'b0000;
                store_wdata = reg_data_b;
            end
        endcase
    end

    // RAM strobes are gated by reset so nothing is written while the unit is held.
    assign ram_en    = !rst && (do_store || do_load);
    assign ram_we    = (!rst && do_store) ? store_we : 4'b0000;
    assign ram_addr  = alu_result[ADDR_W+1:2];
    assign ram_wdata = store_wdata;

    assign lane_half = ld_offset[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        lane_byte = ram_rdata[7:0];
        case (ld_offset)
            2'd0: lane_byte = ram_rdata[7:0];
            2'd1: lane_byte = ram_rdata[15:8];
            2'd2: lane_byte = ram_rdata[23:16];
            2'd3: lane_byte = ram_rdata[31:24];
            default: lane_byte = ram_rdata[7:0];
        endcase
    end

    always_comb begin
        load_value = ram_rdata;
        case (ld_op)
            OP_LB:   load_value = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_value = {24'h0, lane_byte};
            OP_LH:   load_value = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_value = {16'h0, lane_half};
            default: load_value = ram_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ld_offset      <= 2'b00;
            ld_op          <= 8'h00;
            ld_rd          <= 5'd0;
            wb_valid       <= 1'b0;
            wb_reg_wr_en   <= 1'b0;
            wb_rd_addr     <= 5'd0;
            wb_data        <= 32'h0;
            misaligned_err <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wb_rd_addr <= rd_addr;
                        if (illegal) begin
                            wb_valid       <= 1'b1;
                            wb_reg_wr_en   <= 1'b0;
                            misaligned_err <= 1'b0;
                        end else if (misaligned) begin
                            wb_valid       <= 1'b1;
                            wb_reg_wr_en   <= 1'b0;
                            misaligned_err <= 1'b1;
                        end else if (mem_wr_en) begin
                            wb_valid       <= 1'b1;
                            wb_reg_wr_en   <= 1'b0;
                            misaligned_err <= 1'b0;
                        end else if (mem_rd_en) begin
                            ld_offset <= offset;
                            ld_op     <= alu_operation;
                            ld_rd     <= rd_addr;
                            state     <= LOAD_WAIT;
                        end else begin
                            wb_valid       <= 1'b1;
                            wb_data        <= alu_result;
                            wb_reg_wr_en   <= ex_reg_wr_en;
                            misaligned_err <= 1'b0;
                        end
                    end
                end
                LOAD_WAIT: begin
                    state <= IDLE;
                    if (!flush) begin
                        wb_valid       <= 1'b1;
                        wb_data        <= load_value;
                        wb_reg_wr_en   <= 1'b1;
                        wb_rd_addr     <= ld_rd;
                        misaligned_err <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of request vectors with a
// writeback scoreboard, plus hand-written flush and reset sequences.
module tb_mem_access_unit;

    localparam logic [7:0] OP_LB  = 8'h10;
    localparam logic [7:0] OP_LH  = 8'h11;
    localparam logic [7:0] OP_LW  = 8'h12;
    localparam logic [7:0] OP_LBU = 8'h13;
    localparam logic [7:0] OP_LHU = 8'h14;
    localparam logic [7:0] OP_SB  = 8'h18;
    localparam logic [7:0] OP_SH  = 8'h19;
    localparam logic [7:0] OP_SW  = 8'h1A;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_BAD = 8'hFF;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        flush;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        ex_reg_wr_en;
    logic [7:0]  alu_operation;
    logic [31:0] alu_result;
    logic [31:0] reg_data_b;
    logic [4:0]  rd_addr;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        wb_valid;
    logic        wb_reg_wr_en;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        misaligned_err;

    mem_access_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .flush(flush),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .ex_reg_wr_en(ex_reg_wr_en),
        .alu_operation(alu_operation), .alu_result(alu_result), .reg_data_b(reg_data_b),
        .rd_addr(rd_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .wb_valid(wb_valid),
        .wb_reg_wr_en(wb_reg_wr_en), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .misaligned_err(misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM with one cycle of read latency.
    logic [31:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        regwr;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] b;
        logic [4:0]  rda;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [7:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_chk;
        logic        exp_regwr;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        chk;
        logic        regwr;
        logic [4:0]  rd;
        logic        mis;
    } exp_t;

    exp_t scoreboard[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Every writeback pulse must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_wb_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = scoreboard.pop_front();
                checkOutput("wb_latency", cyc, e.due);
                checkOutput("wb_reg_wr_en", {31'd0, wb_reg_wr_en}, {31'd0, e.regwr});
                checkOutput("misaligned_err", {31'd0, misaligned_err}, {31'd0, e.mis});
                if (e.regwr) checkOutput("wb_rd_addr", {27'd0, wb_rd_addr}, {27'd0, e.rd});
                if (e.chk)   checkOutput("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic driveIdle();
        ex_valid = 1'b0; flush = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        ex_reg_wr_en = 1'b0; alu_operation = 8'h00; alu_result = 32'h0;
        reg_data_b = 32'h0; rd_addr = 5'd0;
    endtask

    // Called just after a rising edge; returns just after the edge that ends the request.
    task automatic applyStimulus(input vec_t v);
        int lat;
        exp_t e;
        ex_valid = 1'b1; flush = 1'b0; mem_rd_en = v.rd; mem_wr_en = v.wr;
        ex_reg_wr_en = v.regwr; alu_operation = v.op; alu_result = v.addr;
        reg_data_b = v.b; rd_addr = v.rda;
        lat = (v.rd && !v.wr && v.exp_en) ? 2 : 1;
        @(negedge clk);
        checkOutput("ex_ready", {31'd0, ex_ready}, 32'd1);
        checkOutput("ram_en", {31'd0, ram_en}, {31'd0, v.exp_en});
        checkOutput("ram_we", {28'd0, ram_we}, {28'd0, v.exp_we});
        if (v.exp_en) checkOutput("ram_addr", {24'd0, ram_addr}, {24'd0, v.exp_addr});
        if (v.exp_we != 4'b0000) checkOutput("ram_wdata", ram_wdata, v.exp_wdata);
        e.due = cyc + lat; e.data = v.exp_data; e.chk = v.exp_chk;
        e.regwr = v.exp_regwr; e.rd = v.rda; e.mis = v.exp_mis;
        scoreboard.push_back(e);
        @(posedge clk); #1;
        driveIdle();
        if (lat == 2) begin
            @(negedge clk);
            checkOutput("ex_ready_load_wait", {31'd0, ex_ready}, 32'd0);
            checkOutput("ram_en_load_wait", {31'd0, ram_en}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs[19];
    vec_t v;

    initial begin
        //              rd   wr   rgw  op      addr          b             rda  en   we       addr   wdata         data          chk  rgw  mis
        vecs[0]  = '{1'b0,1'b1,1'b0,OP_SW, 32'h10,       32'hDEADBEEF, 5'd1,1'b1,4'b1111,8'h04,32'hDEADBEEF,32'h0,       1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b1,OP_LW, 32'h10,       32'h0,        5'd5,1'b1,4'b0000,8'h04,32'h0,       32'hDEADBEEF,1'b1,1'b1,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,OP_SB, 32'h13,       32'h80,       5'd1,1'b1,4'b1000,8'h04,32'h80808080,32'h0,       1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b1,OP_LB, 32'h13,       32'h0,        5'd6,1'b1,4'b0000,8'h04,32'h0,       32'hFFFFFF80,1'b1,1'b1,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b1,OP_LBU,32'h13,       32'h0,        5'd7,1'b1,4'b0000,8'h04,32'h0,       32'h00000080,1'b1,1'b1,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,OP_SH, 32'h12,       32'h8001,     5'd1,1'b1,4'b1100,8'h04,32'h80018001,32'h0,       1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b1,OP_LH, 32'h12,       32'h0,        5'd8,1'b1,4'b0000,8'h04,32'h0,       32'hFFFF8001,1'b1,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b1,OP_LHU,32'h12,       32'h0,        5'd9,1'b1,4'b0000,8'h04,32'h0,       32'h00008001,1'b1,1'b1,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b1,OP_LW, 32'h06,       32'h0,        5'd2,1'b0,4'b0000,8'h01,32'h0,       32'h0,       1'b0,1'b0,1'b1};
        vecs[9]  = '{1'b0,1'b1,1'b0,OP_SH, 32'h03,       32'h5555,     5'd2,1'b0,4'b0000,8'h00,32'h0,       32'h0,       1'b0,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b0,1'b1,OP_ADD,32'h1234,     32'h0,        5'd3,1'b0,4'b0000,8'h00,32'h0,       32'h00001234,1'b1,1'b1,1'b0};
        vecs[11] = '{1'b1,1'b1,1'b1,OP_LW, 32'h10,       32'h0,        5'd4,1'b0,4'b0000,8'h04,32'h0,       32'h0,       1'b0,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b0,OP_SW, 32'h420,      32'hCAFEF00D, 5'd1,1'b1,4'b1111,8'h08,32'hCAFEF00D,32'h0,       1'b0,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b1,OP_LW, 32'h20,       32'h0,        5'd10,1'b1,4'b0000,8'h08,32'h0,      32'hCAFEF00D,1'b1,1'b1,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b1,OP_LB, 32'h11,       32'h0,        5'd11,1'b1,4'b0000,8'h04,32'h0,      32'hFFFFFFBE,1'b1,1'b1,1'b0};
        vecs[15] = '{1'b0,1'b1,1'b0,OP_SB, 32'h21,       32'h12345677, 5'd1,1'b1,4'b0010,8'h08,32'h77777777,32'h0,       1'b0,1'b0,1'b0};
        vecs[16] = '{1'b1,1'b0,1'b1,OP_LBU,32'h21,       32'h0,        5'd12,1'b1,4'b0000,8'h08,32'h0,      32'h00000077,1'b1,1'b1,1'b0};
        vecs[17] = '{1'b0,1'b0,1'b0,OP_ADD,32'hA5A5A5A5, 32'h0,        5'd13,1'b0,4'b0000,8'h00,32'h0,      32'hA5A5A5A5,1'b1,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b1,1'b0,OP_BAD,32'h24,       32'h99999999, 5'd1,1'b1,4'b0000,8'h09,32'h0,       32'h0,       1'b0,1'b0,1'b0};

        // Reset: a store presented during reset must not reach the RAM.
        rst = 1'b1;
        driveIdle();
        ex_valid = 1'b1; mem_wr_en = 1'b1; alu_operation = OP_SW; alu_result = 32'h10;
        reg_data_b = 32'h11111111;
        @(negedge clk);
        checkOutput("reset_ram_en", {31'd0, ram_en}, 32'd0);
        checkOutput("reset_ram_we", {28'd0, ram_we}, 32'd0);
        checkOutput("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("reset_wb_data", wb_data, 32'h0);
        checkOutput("reset_wb_reg_wr_en", {31'd0, wb_reg_wr_en}, 32'd0);
        checkOutput("reset_misaligned_err", {31'd0, misaligned_err}, 32'd0);
        driveIdle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", {31'd0, ex_ready}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) applyStimulus(vecs[i]);

        // Load killed by flush in LOAD_WAIT, then a pass-through right after.
        ex_valid = 1'b1; mem_rd_en = 1'b1; alu_operation = OP_LW; alu_result = 32'h10; rd_addr = 5'd14;
        @(negedge clk);
        checkOutput("flush_load_ram_en", {31'd0, ram_en}, 32'd1);
        @(posedge clk); #1;
        driveIdle();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_ex_ready", {31'd0, ex_ready}, 32'd0);
        @(posedge clk); #1;
        v = '{1'b0,1'b0,1'b1,OP_ADD,32'h1234,32'h0,5'd15,1'b0,4'b0000,8'h00,32'h0,32'h1234,1'b1,1'b1,1'b0};
        applyStimulus(v);

        // A request arriving with flush in IDLE is dropped entirely.
        ex_valid = 1'b1; flush = 1'b1; mem_wr_en = 1'b1; alu_operation = OP_SW; alu_result = 32'h30;
        reg_data_b = 32'h12121212;
        @(negedge clk);
        checkOutput("flush_idle_ram_en", {31'd0, ram_en}, 32'd0);
        checkOutput("flush_idle_ram_we", {28'd0, ram_we}, 32'd0);
        @(posedge clk); #1;
        driveIdle();

        // A store accepted earlier still completes when flush arrives next cycle.
        ex_valid = 1'b1; mem_wr_en = 1'b1; alu_operation = OP_SW; alu_result = 32'h30;
        reg_data_b = 32'h34343434;
        @(negedge clk);
        checkOutput("store_then_flush_we", {28'd0, ram_we}, 32'hF);
        scoreboard.push_back('{cyc + 1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0});
        @(posedge clk); #1;
        driveIdle();
        flush = 1'b1;
        @(posedge clk); #1;
        driveIdle();

        // Reset while a load is waiting: pending load is abandoned.
        ex_valid = 1'b1; mem_rd_en = 1'b1; alu_operation = OP_LB; alu_result = 32'h13; rd_addr = 5'd16;
        @(posedge clk); #1;
        driveIdle();
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_load_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("rst_mid_load_ram_en", {31'd0, ram_en}, 32'd0);
        checkOutput("rst_mid_load_wb_data", wb_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_load_ex_ready", {31'd0, ex_ready}, 32'd1);
        repeat (3) @(posedge clk);

        for (int k = 0; k < 10 && scoreboard.size() > 0; k++) @(posedge clk);
        checkOutput("scoreboard_drained", scoreboard.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
